// File: rtl/uart_rx_core_pkg.sv
// Shared definitions for the UART receive path: FSM encoding and default frame width.
package uart_rx_core_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO for received bytes; registered head/valid/full/count, no bypass.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q, valid_d;
  logic             full_q, full_d;
  logic             do_push, do_pop;

  // Next-state: a push into a full FIFO is accepted only when a pop frees the slot this cycle.
  always_comb begin
    do_pop   = pop & valid_q;
    do_push  = push & (~full_q | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
    valid_d = (count_d != '0);
    full_d  = (count_d == CW'(DEPTH));
    head_d  = valid_d ? mem_d[rd_ptr_d] : '0;
  end

  // Storage, pointers and registered status.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
    end
  end

  assign head  = head_q;
  assign valid = valid_q;
  assign full  = full_q;
  assign count = count_q;

endmodule

// File: rtl/uart_rx_core.sv
// UART 8N1 receiver: synchroniser, centre-sampling FSM, stop-bit check, output FIFO.
module uart_rx_core
  import uart_rx_core_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = UART_DATA_BITS,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          frame_err,
  output logic                          overrun
);

  localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int unsigned HALF_LAST = CLKS_PER_BIT / 2 - 1;
  localparam int unsigned BIT_LAST  = CLKS_PER_BIT - 1;

  logic                 rx_meta_q, rxs_q;
  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 push_req_q, push_req_d;
  logic                 ferr_req_q, ferr_req_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;

  logic                 fifo_valid, fifo_full, fifo_pop;
  logic [DATA_BITS-1:0] fifo_head;

  // Two-flop synchroniser; idles high so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
    end
  end

  // Frame FSM: start qualified at half-bit, data/stop sampled at bit centres.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    push_req_d = 1'b0;
    ferr_req_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rxs_q) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_W'(HALF_LAST)) begin
          cnt_d = '0;
          bit_d = '0;
          state_d = rxs_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_W'(BIT_LAST)) begin
          cnt_d   = '0;
          shreg_d = {rxs_q, shreg_q[DATA_BITS-1:1]};
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_W'(BIT_LAST)) begin
          cnt_d = '0;
          if (rxs_q) begin
            push_req_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            ferr_req_d = 1'b1;
            state_d    = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        cnt_d = '0;
        if (rxs_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status pulses line up with the FIFO write one cycle after the stop sample.
  always_comb begin
    fifo_pop    = fifo_valid & rx_ready;
    frame_err_d = ferr_req_q;
    overrun_d   = push_req_q & fifo_full & ~fifo_pop;
    busy_d      = (state_d != ST_IDLE);
  end

  // FSM and status registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      push_req_q  <= 1'b0;
      ferr_req_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      push_req_q  <= push_req_d;
      ferr_req_q  <= ferr_req_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push_req_q),
    .push_data (shreg_q),
    .pop       (rx_ready),
    .head      (fifo_head),
    .valid     (fifo_valid),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign rx_data   = fifo_head;
  assign rx_valid  = fifo_valid;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: directed scenarios plus randomized frames against a queue model.
module tb_uart_rx_core;

  logic       clk = 1'b0;
  logic       resetn;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] fifo_count;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  uart_rx_core #(
    .CLKS_PER_BIT (16),
    .DATA_BITS    (8),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .fifo_count (fifo_count),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  byte unsigned mq[$];
  int          sched_byte[int];
  bit          sched_ferr[int];
  bit          busy_sched[int];
  bit          m_ferr = 1'b0;
  bit          m_ovr = 1'b0;
  int          ovr_seen = 0;
  int          ferr_seen = 0;
  int          last_pop = -1;
  bit          rdy_rand = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: edge-indexed schedule of frame outcomes feeding a 4-entry queue.
  always @(posedge clk) begin
    bit pop;
    cyc++;
    if (!resetn) begin
      mq.delete();
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
    end else begin
      pop    = (mq.size() != 0) && rx_ready;
      m_ferr = sched_ferr.exists(cyc);
      m_ovr  = 1'b0;
      if (pop) void'(mq.pop_front());
      if (sched_byte.exists(cyc)) begin
        if (mq.size() < 4) mq.push_back(byte'(sched_byte[cyc]));
        else m_ovr = 1'b1;
      end
    end
  end

  // Compare every output on the falling edge.
  always @(negedge clk) begin
    if (!resetn) begin
      check_val("rst_rx_valid", 32'(rx_valid), 32'd0);
      check_val("rst_rx_data", 32'(rx_data), 32'd0);
      check_val("rst_fifo_count", 32'(fifo_count), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_frame_err", 32'(frame_err), 32'd0);
      check_val("rst_overrun", 32'(overrun), 32'd0);
    end else begin
      check_val("rx_valid", 32'(rx_valid), 32'(mq.size() != 0));
      check_val("rx_data", 32'(rx_data), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
      check_val("fifo_count", 32'(fifo_count), 32'(mq.size()));
      check_val("frame_err", 32'(frame_err), 32'(m_ferr));
      check_val("overrun", 32'(overrun), 32'(m_ovr));
      check_val("busy", 32'(busy), 32'(busy_sched.exists(cyc)));
      if (overrun) ovr_seen++;
      if (frame_err) ferr_seen++;
      if (rx_valid && rx_ready) last_pop = int'(rx_data);
    end
  end

  // Random consumer back-pressure.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) rx_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Hold rx at v for n clocks; always returns 1 time unit after a rising edge.
  task automatic bit_time(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one frame and record when its result must appear (T0 = drive edge + 3).
  task automatic send_frame(input logic [7:0] d, input bit good, input int hold);
    int e;
    int t0;
    int r;
    e  = cyc;
    t0 = e + 3;
    if (good) begin
      for (int k = t0; k < t0 + 152; k++) busy_sched[k] = 1'b1;
      sched_byte[t0 + 153] = int'(d);
    end else begin
      r = e + 16 * (10 + hold);
      for (int k = t0; k <= r + 2; k++) busy_sched[k] = 1'b1;
      sched_ferr[t0 + 153] = 1'b1;
    end
    bit_time(1'b0, 16);
    for (int i = 0; i < 8; i++) bit_time(d[i], 16);
    if (good) begin
      bit_time(1'b1, 16);
    end else begin
      bit_time(1'b0, 16 * (1 + hold));
      rx = 1'b1;
    end
  endtask

  task automatic send_glitch();
    int t0;
    t0 = cyc + 3;
    for (int k = t0; k < t0 + 8; k++) busy_sched[k] = 1'b1;
    bit_time(1'b0, 4);
    bit_time(1'b1, 20);
  endtask

  initial begin
    int f0;
    int o0;
    byte unsigned exp5[4];
    resetn   = 1'b0;
    rx       = 1'b1;
    rx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_valid", 32'(rx_valid), 32'd0);
    check_val("reset_count", 32'(fifo_count), 32'd0);
    resetn = 1'b1;
    bit_time(1'b1, 10);

    // 1: single good byte with consumer ready
    rx_ready = 1'b1;
    f0 = ferr_seen;
    o0 = ovr_seen;
    send_frame(8'h55, 1'b1, 0);
    bit_time(1'b1, 10);
    check_val("t1_ferr", 32'(ferr_seen - f0), 32'd0);
    check_val("t1_ovr", 32'(ovr_seen - o0), 32'd0);
    check_val("t1_byte", 32'(last_pop), 32'h55);

    // 2: short glitch is ignored
    send_glitch();
    bit_time(1'b1, 10);

    // 3: bad stop, long break, then a clean byte
    f0 = ferr_seen;
    send_frame(8'hA3, 1'b0, 40);
    bit_time(1'b1, 10);
    check_val("t3_count", 32'(fifo_count), 32'd0);
    send_frame(8'h0F, 1'b1, 0);
    bit_time(1'b1, 10);
    check_val("t3_ferr", 32'(ferr_seen - f0), 32'd1);
    check_val("t3_byte", 32'(last_pop), 32'h0F);

    // 4: overrun on the fifth back-to-back byte, then drain
    rx_ready = 1'b0;
    o0 = ovr_seen;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 0);
    bit_time(1'b1, 4);
    check_val("t4_count", 32'(fifo_count), 32'd4);
    check_val("t4_ovr", 32'(ovr_seen - o0), 32'd1);
    rx_ready = 1'b1;
    bit_time(1'b1, 6);
    check_val("t4_valid", 32'(rx_valid), 32'd0);
    check_val("t4_data", 32'(rx_data), 32'd0);
    check_val("t4_last", 32'(last_pop), 32'h04);

    // 5: push and pop on the same edge while full
    rx_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 0);
    o0 = ovr_seen;
    fork
      send_frame(8'h66, 1'b1, 0);
      begin
        repeat (155) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
    join
    bit_time(1'b1, 4);
    check_val("t5_count", 32'(fifo_count), 32'd4);
    check_val("t5_ovr", 32'(ovr_seen - o0), 32'd0);
    exp5[0] = 8'h02; exp5[1] = 8'h03; exp5[2] = 8'h04; exp5[3] = 8'h66;
    for (int i = 0; i < 4; i++) begin
      check_val("t5_drain", 32'(rx_data), 32'(exp5[i]));
      rx_ready = 1'b1;
      @(posedge clk);
      #1 rx_ready = 1'b0;
    end
    check_val("t5_empty", 32'(rx_valid), 32'd0);

    // 6: reset in the middle of bit 3 of 0x7E
    begin
      int e;
      e = cyc;
      for (int k = e + 3; k <= e + 72; k++) busy_sched[k] = 1'b1;
      bit_time(1'b0, 16);
      bit_time(1'b0, 16);
      bit_time(1'b1, 16);
      bit_time(1'b1, 16);
      bit_time(1'b1, 8);
    end
    resetn = 1'b0;
    sched_byte.delete();
    sched_ferr.delete();
    busy_sched.delete();
    #1;
    check_val("t6_busy", 32'(busy), 32'd0);
    check_val("t6_valid", 32'(rx_valid), 32'd0);
    check_val("t6_count", 32'(fifo_count), 32'd0);
    rx = 1'b1;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    bit_time(1'b1, 40);
    check_val("t6_nobyte", 32'(rx_valid), 32'd0);
    rx_ready = 1'b1;
    send_frame(8'h81, 1'b1, 0);
    bit_time(1'b1, 10);
    check_val("t6_byte", 32'(last_pop), 32'h81);

    // Randomized frames, glitches and frame errors under random back-pressure
    rdy_rand = 1'b1;
    for (int n = 0; n < 30; n++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel == 0) send_glitch();
      else if (sel <= 2) send_frame(8'($urandom), 1'b0, int'($urandom_range(0, 3)));
      else send_frame(8'($urandom), 1'b1, 0);
      bit_time(1'b1, int'($urandom_range(8, 40)));
    end
    rdy_rand = 1'b0;
    @(posedge clk);
    #1 rx_ready = 1'b1;
    for (int w = 0; w < 50 && rx_valid; w++) begin
      @(posedge clk);
      #1;
    end
    check_val("final_count", 32'(fifo_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
